// File: rtl/id_exe_pipe_reg.sv
// id_exe_pipe_reg: ID/EXE pipeline register with flush, freeze, bubble insertion and a saturating stall counter.
module id_exe_pipe_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        freeze,
   input  logic        bubble,
   input  logic        wb_en_in,
   input  logic        mem_r_en_in,
   input  logic        mem_w_en_in,
   input  logic        b_in,
   input  logic        s_in,
   input  logic [3:0]  exe_cmd_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] val_rn_in,
   input  logic [31:0] val_rm_in,
   input  logic        imm_in,
   input  logic [11:0] shift_operand_in,
   input  logic [23:0] signed_imm_24_in,
   input  logic [3:0]  dest_in,
   input  logic [3:0]  src1_in,
   input  logic [3:0]  src2_in,
   input  logic [3:0]  status_in,
   output logic        wb_en_out,
   output logic        mem_r_en_out,
   output logic        mem_w_en_out,
   output logic        b_out,
   output logic        s_out,
   output logic [3:0]  exe_cmd_out,
   output logic [31:0] pc_out,
   output logic [31:0] val_rn_out,
   output logic [31:0] val_rm_out,
   output logic        imm_out,
   output logic [11:0] shift_operand_out,
   output logic [23:0] signed_imm_24_out,
   output logic [3:0]  dest_out,
   output logic [3:0]  src1_out,
   output logic [3:0]  src2_out,
   output logic [3:0]  status_out,
   output logic        valid_out,
   output logic [15:0] stall_count
);
   logic kill;
   assign kill = rst || flush;
   always_ff @(posedge clk) begin
      if (kill) begin
         {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, valid_out} <= '0;
         exe_cmd_out       <= '0;
         pc_out            <= '0;
         val_rn_out        <= '0;
         val_rm_out        <= '0;
         imm_out           <= '0;
         shift_operand_out <= '0;
         signed_imm_24_out <= '0;
         dest_out          <= '0;
         src1_out          <= '0;
         src2_out          <= '0;
         status_out        <= '0;
      end else if (!freeze) begin
         // a bubble keeps the datapath moving but strips every side-effecting control bit
         {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out} <=
            bubble ? 5'b0 : {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in};
         valid_out         <= !bubble;
         exe_cmd_out       <= exe_cmd_in;
         pc_out            <= pc_in;
         val_rn_out        <= val_rn_in;
         val_rm_out        <= val_rm_in;
         imm_out           <= imm_in;
         shift_operand_out <= shift_operand_in;
         signed_imm_24_out <= signed_imm_24_in;
         dest_out          <= dest_in;
         src1_out          <= src1_in;
         src2_out          <= src2_in;
         status_out        <= status_in;
      end
   end
   always_ff @(posedge clk) begin
      if (rst)
         stall_count <= '0;
      else if (!flush && (freeze || bubble) && stall_count != 16'hFFFF)
         stall_count <= stall_count + 16'd1;
   end
endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// tb_id_exe_pipe_reg: scoreboard bench for id_exe_pipe_reg; expected states queued at drive time, compared after each edge.
module tb_id_exe_pipe_reg;
   typedef struct packed {
      logic        valid, wb, mr, mw, b, s;
      logic [3:0]  cmd;
      logic [31:0] pc, rn, rm;
      logic        imm;
      logic [11:0] sh;
      logic [23:0] si;
      logic [3:0]  dest, src1, src2, status;
      logic [15:0] stall;
   } out_t;

   logic clk = 0, rst = 0, flush = 0, freeze = 0, bubble = 0;
   logic wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0, b_in = 0, s_in = 0, imm_in = 0;
   logic [3:0]  exe_cmd_in = 0, dest_in = 0, src1_in = 0, src2_in = 0, status_in = 0;
   logic [31:0] pc_in = 0, val_rn_in = 0, val_rm_in = 0;
   logic [11:0] shift_operand_in = 0;
   logic [23:0] signed_imm_24_in = 0;
   logic wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, valid_out;
   logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, status_out;
   logic [31:0] pc_out, val_rn_out, val_rm_out;
   logic [11:0] shift_operand_out;
   logic [23:0] signed_imm_24_out;
   logic [15:0] stall_count;

   int vectors = 0, errors = 0;
   out_t m = '0, e, obs;
   out_t q[$];

   always #5 clk = ~clk;

   id_exe_pipe_reg dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .bubble(bubble),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
      .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
      .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
      .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .status_in(status_in),
      .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
      .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out), .pc_out(pc_out),
      .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
      .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
      .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .status_out(status_out),
      .valid_out(valid_out), .stall_count(stall_count)
   );

   assign obs = {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out,
                 pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm_24_out,
                 dest_out, src1_out, src2_out, status_out, stall_count};

   function automatic out_t model(input out_t c);
      out_t n = c;
      if (rst) n = '0;
      else if (flush) begin
         n = '0;
         n.stall = c.stall;
      end else begin
         if (!freeze) begin
            n = {!bubble, bubble ? 5'b0 : {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in},
                 exe_cmd_in, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                 signed_imm_24_in, dest_in, src1_in, src2_in, status_in, c.stall};
         end
         if ((freeze || bubble) && c.stall != 16'hFFFF) n.stall = c.stall + 16'd1;
      end
      return n;
   endfunction

   task automatic apply();
      m = model(m);
      q.push_back(m);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_in();
      {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = 6'($urandom);
      {exe_cmd_in, dest_in, src1_in, src2_in, status_in} = 20'($urandom);
      pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
      shift_operand_in = 12'($urandom); signed_imm_24_in = 24'($urandom);
   endtask

   task automatic test_reset();
      rand_in();
      rst = 1; freeze = 1; bubble = 1;
      apply();
      rst = 0; freeze = 0; bubble = 0;
      e = q.pop_front(); vectors++;
      if (obs !== e) begin errors++; $display("FAIL reset: got %h expected %h", obs, e); end
      vectors++;
      if (obs !== '0) begin errors++; $display("FAIL reset_zero: got %h expected 0", obs); end
   endtask

   task automatic test_load();
      rand_in();
      wb_en_in = 1; exe_cmd_in = 4'b0010; val_rn_in = 32'h5; dest_in = 4'd3;
      apply();
      e = q.pop_front(); vectors++;
      if (obs !== e) begin errors++; $display("FAIL load: got %h expected %h", obs, e); end
      vectors++;
      if ({wb_en_out, exe_cmd_out, val_rn_out, dest_out, valid_out} !== {1'b1, 4'b0010, 32'h5, 4'd3, 1'b1}) begin
         errors++;
         $display("FAIL load_fields: got wb=%b cmd=%b rn=%h dest=%0d valid=%b expected 1 0010 5 3 1",
                  wb_en_out, exe_cmd_out, val_rn_out, dest_out, valid_out);
      end
   endtask

   task automatic test_freeze();
      out_t held = obs;
      freeze = 1;
      for (int i = 0; i < 3; i++) begin
         rand_in();
         apply();
         e = q.pop_front(); vectors++;
         if (obs !== e) begin errors++; $display("FAIL freeze%0d: got %h expected %h", i, obs, e); end
      end
      freeze = 0;
      vectors++;
      if ({obs[174:16], stall_count} !== {held[174:16], 16'd3}) begin
         errors++;
         $display("FAIL freeze_hold: got %h stall=%0d expected %h stall=3", obs[174:16], stall_count, held[174:16]);
      end
   endtask

   task automatic test_flush_freeze();
      rand_in();
      flush = 1; freeze = 1; mem_w_en_in = 1;
      apply();
      flush = 0; freeze = 0;
      e = q.pop_front(); vectors++;
      if (obs !== e) begin errors++; $display("FAIL flush_freeze: got %h expected %h", obs, e); end
      vectors++;
      if ({valid_out, mem_w_en_out, wb_en_out, stall_count} !== {3'b000, 16'd3}) begin
         errors++;
         $display("FAIL flush_ctrl: got valid=%b mw=%b wb=%b stall=%0d expected 0 0 0 3",
                  valid_out, mem_w_en_out, wb_en_out, stall_count);
      end
   endtask

   task automatic test_bubble();
      rand_in();
      bubble = 1; mem_r_en_in = 1; wb_en_in = 1; src1_in = 4'd7;
      apply();
      bubble = 0;
      e = q.pop_front(); vectors++;
      if (obs !== e) begin errors++; $display("FAIL bubble: got %h expected %h", obs, e); end
      vectors++;
      if ({mem_r_en_out, wb_en_out, valid_out, src1_out, stall_count} !== {3'b000, 4'd7, 16'd4}) begin
         errors++;
         $display("FAIL bubble_fields: got mr=%b wb=%b valid=%b src1=%0d stall=%0d expected 0 0 0 7 4",
                  mem_r_en_out, wb_en_out, valid_out, src1_out, stall_count);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         rand_in();
         flush = ($urandom_range(0, 7) == 0);
         freeze = ($urandom_range(0, 3) == 0);
         bubble = ($urandom_range(0, 3) == 0);
         apply();
         e = q.pop_front(); vectors++;
         if (obs !== e) begin errors++; $display("FAIL b2b%0d: got %h expected %h", i, obs, e); end
      end
      {flush, freeze, bubble} = 3'b0;
   endtask

   task automatic test_rst_mid_freeze();
      rand_in();
      apply();
      e = q.pop_front();
      freeze = 1;
      rand_in();
      apply();
      e = q.pop_front();
      rst = 1;
      apply();
      rst = 0; freeze = 0;
      e = q.pop_front(); vectors++;
      if (obs !== e || obs !== '0) begin errors++; $display("FAIL rst_mid_freeze: got %h expected %h", obs, e); end
      rand_in();
      apply();
      e = q.pop_front(); vectors++;
      if (obs !== e || valid_out !== 1'b1) begin errors++; $display("FAIL resume: got %h expected %h", obs, e); end
   endtask

   task automatic test_saturation();
      freeze = 1;
      for (int i = 0; i < 65540; i++) begin
         rand_in();
         apply();
         e = q.pop_front(); vectors++;
         if (obs !== e) begin errors++; $display("FAIL sat%0d: got %h expected %h", i, obs, e); end
      end
      vectors++;
      if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_value: got %h expected ffff", stall_count); end
      rst = 1;
      apply();
      rst = 0; freeze = 0;
      e = q.pop_front(); vectors++;
      if (obs !== e || obs !== '0) begin errors++; $display("FAIL sat_reset: got %h expected 0", obs); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_freeze();
      test_flush_freeze();
      test_bubble();
      test_back_to_back();
      test_rst_mid_freeze();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/id_exe_pipe_reg.md
ID_EXE_PIPE_REG -- requirements
Module: id_exe_pipe_reg

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port flush  input  1  branch-taken squash of the instruction entering EXE.
REQ-004 SHALL have port freeze  input  1  hold all registered state (memory stall).
REQ-005 SHALL have port bubble  input  1  hazard-detected; insert NOP into EXE.
REQ-006 SHALL have inputs wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  input  1 each  decoded control bits from decode.
REQ-007 SHALL have port exe_cmd_in  input  4  execute command.
REQ-008 SHALL have ports pc_in, val_rn_in, val_rm_in  input  32 each  PC+4 and register-file reads.
REQ-009 SHALL have ports imm_in  input  1; shift_operand_in  input  12; signed_imm_24_in  input  24; dest_in, src1_in, src2_in  input  4 each.
REQ-010 SHALL have port status_in  input  4  NZCV flags, sampled for carry-consuming commands.
REQ-011 SHALL have one registered output per input of REQ-006..REQ-010, same width, suffix _out in place of _in.
REQ-012 SHALL have port valid_out  output  1  high when EXE holds a real instruction.
REQ-013 SHALL have port stall_count  output  16  cycles spent in freeze or bubble since reset, saturating.

Function
REQ-014 SHALL update on each rising clk edge per priority: rst > flush > freeze > bubble > load.
REQ-015 SHALL, on load (no rst/flush/freeze/bubble), capture every _in into its _out and set valid_out=1; latency one cycle.
REQ-016 SHALL, on flush, clear wb_en, mem_r_en, mem_w_en, b, s, valid_out to 0, exe_cmd_out to 4'b0000, all other outputs to 0.
REQ-017 SHALL, on freeze without flush, hold every output and valid_out unchanged.
REQ-018 SHALL, on bubble without flush/freeze, clear wb_en, mem_r_en, mem_w_en, b, s, valid_out to 0; capture datapath fields (pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, src1, src2, status, exe_cmd) normally.
REQ-019 SHALL never produce a state where valid_out=0 while any of wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out is 1.
REQ-020 SHALL increment stall_count by 1 on each edge where freeze=1 or bubble=1 (and no rst/flush), saturating at 16'hFFFF.
REQ-021 SHALL not increment stall_count on a flush edge, even with freeze or bubble high.
REQ-022 SHALL have no combinational path from any input to any output.

Reset
REQ-023 SHALL, when rst=1 at an edge, set every output including valid_out and stall_count to 0, regardless of other inputs.
REQ-024 SHALL, on rst asserted mid-freeze, discard held state and leave reset values on the next edge.
REQ-025 SHALL resume normal loading on the first edge after rst deasserts.

Verification
REQ-026 Load: wb_en_in=1, exe_cmd_in=4'b0010, val_rn_in=32'h0000_0005, dest_in=4'd3 -> next edge wb_en_out=1, exe_cmd_out=4'b0010, val_rn_out=5, dest_out=3, valid_out=1.
REQ-027 Freeze: after REQ-026, freeze=1 for 3 cycles with changed inputs -> outputs unchanged, stall_count=3.
REQ-028 Flush+freeze: flush=1, freeze=1, mem_w_en_in=1 -> next edge all controls 0, valid_out=0, stall_count unchanged.
REQ-029 Bubble: bubble=1, mem_r_en_in=1, wb_en_in=1, src1_in=4'd7 -> mem_r_en_out=0, wb_en_out=0, valid_out=0, src1_out=7, stall_count+1.
REQ-030 Saturation: hold freeze=1 for 65,540 cycles -> stall_count stops at 16'hFFFF; then rst=1 one cycle -> all outputs 0.
